// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter sharing the ftdiController transmit byte channel between
// NUM_REQ four-phase byte producers; a grant is held for a whole packet.
module ftdi_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic [NUM_REQ-1:0]     in_req_tx_hsk_req,
  input  logic [8*NUM_REQ-1:0]   in_req_tx_data,
  input  logic [NUM_REQ-1:0]     in_req_last,
  output logic [NUM_REQ-1:0]     out_req_tx_hsk_ack,
  output logic                   out_tx_hsk_req,
  input  logic                   in_tx_hsk_ack,
  output logic [7:0]             out_tx_data,
  output logic [NUM_REQ-1:0]     out_grant,
  output logic                   out_busy,
  output logic                   out_timeout
);

  localparam int          IDX_W        = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RELAY    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
  logic [IDX_W-1:0]   gnt_idx_r, gnt_idx_nxt_s;
  logic               last_r, last_nxt_s;
  logic [15:0]        cnt_r, cnt_nxt_s;
  logic               tx_req_r, tx_req_nxt_s;
  logic [7:0]         tx_data_r, tx_data_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  logic [NUM_REQ-1:0] req_ack_r, req_ack_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               timeout_r, timeout_nxt_s;

  logic [7:0]         req_byte_s [NUM_REQ];
  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] res;
    if (int'(idx) >= NUM_REQ - 1) begin
      res = {IDX_W{1'b0}};
    end else begin
      res = idx + IDX_W'(1);
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = {NUM_REQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Scan upward from the pointer with wrap; first active request wins.
  function automatic logic [IDX_W:0] find_winner(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] scan;
    logic [IDX_W-1:0] idx;
    logic             found;
    scan  = start;
    idx   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[scan]) begin
        found = 1'b1;
        idx   = scan;
      end else begin
        idx   = idx;
      end
      scan = wrap_inc(scan);
    end
    return {found, idx};
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign req_byte_s[i] = in_req_tx_data[8*i +: 8];
  end

  assign {win_found_s, win_idx_s} = find_winner(in_req_tx_hsk_req, ptr_r);

  // Next-state and next-output decode for the grant/handshake FSM.
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    gnt_idx_nxt_s = gnt_idx_r;
    last_nxt_s    = last_r;
    cnt_nxt_s     = cnt_r;
    tx_req_nxt_s  = tx_req_r;
    tx_data_nxt_s = tx_data_r;
    grant_nxt_s   = grant_r;
    req_ack_nxt_s = req_ack_r;
    timeout_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          gnt_idx_nxt_s = win_idx_s;
          grant_nxt_s   = one_hot(win_idx_s);
          tx_data_nxt_s = req_byte_s[win_idx_s];
          last_nxt_s    = in_req_last[win_idx_s];
          tx_req_nxt_s  = 1'b1;
          state_nxt_s   = WAIT_ACK;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      WAIT_ACK: begin
        if (in_tx_hsk_ack) begin
          tx_req_nxt_s  = 1'b0;
          req_ack_nxt_s = one_hot(gnt_idx_r);
          state_nxt_s   = RELAY;
        end else begin
          state_nxt_s   = WAIT_ACK;
        end
      end
      RELAY: begin
        // Both sides must have returned to zero before the byte is retired.
        if (!in_req_tx_hsk_req[gnt_idx_r] && !in_tx_hsk_ack) begin
          req_ack_nxt_s = {NUM_REQ{1'b0}};
          if (last_r) begin
            ptr_nxt_s   = wrap_inc(gnt_idx_r);
            grant_nxt_s = {NUM_REQ{1'b0}};
            state_nxt_s = IDLE;
          end else begin
            cnt_nxt_s   = 16'd0;
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s   = RELAY;
        end
      end
      HOLD: begin
        if (in_req_tx_hsk_req[gnt_idx_r]) begin
          tx_data_nxt_s = req_byte_s[gnt_idx_r];
          last_nxt_s    = in_req_last[gnt_idx_r];
          tx_req_nxt_s  = 1'b1;
          state_nxt_s   = WAIT_ACK;
        end else if (cnt_r == TIMEOUT_LAST) begin
          timeout_nxt_s = 1'b1;
          grant_nxt_s   = {NUM_REQ{1'b0}};
          ptr_nxt_s     = wrap_inc(gnt_idx_r);
          state_nxt_s   = IDLE;
        end else begin
          cnt_nxt_s     = cnt_r + 16'd1;
        end
      end
      default: begin
        tx_req_nxt_s  = 1'b0;
        grant_nxt_s   = {NUM_REQ{1'b0}};
        req_ack_nxt_s = {NUM_REQ{1'b0}};
        ptr_nxt_s     = {IDX_W{1'b0}};
        state_nxt_s   = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // FSM state, round-robin pointer and per-packet bookkeeping.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_r   <= IDLE;
      ptr_r     <= {IDX_W{1'b0}};
      gnt_idx_r <= {IDX_W{1'b0}};
      last_r    <= 1'b0;
      cnt_r     <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      gnt_idx_r <= gnt_idx_nxt_s;
      last_r    <= last_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      tx_req_r  <= 1'b0;
      tx_data_r <= 8'h00;
      grant_r   <= {NUM_REQ{1'b0}};
      req_ack_r <= {NUM_REQ{1'b0}};
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      tx_req_r  <= tx_req_nxt_s;
      tx_data_r <= tx_data_nxt_s;
      grant_r   <= grant_nxt_s;
      req_ack_r <= req_ack_nxt_s;
      busy_r    <= busy_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign out_tx_hsk_req     = tx_req_r;
  assign out_tx_data        = tx_data_r;
  assign out_grant          = grant_r;
  assign out_req_tx_hsk_ack = req_ack_r;
  assign out_busy           = busy_r;
  assign out_timeout        = timeout_r;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Scoreboard bench for ftdi_tx_arbiter: requester agents and a downstream partner
// drive four-phase handshakes; a monitor compares every presented byte.
module tb_ftdi_tx_arbiter;

  logic        clk = 1'b0;
  logic        in_rst;
  logic [2:0]  req_vec;
  logic [23:0] data_vec;
  logic [2:0]  last_vec;
  logic [2:0]  ack_vec;
  logic        tx_req;
  logic        tx_ack = 1'b0;
  logic [7:0]  tx_data;
  logic [2:0]  grant;
  logic        busy;
  logic        tmo;

  int lat = 1;
  int checks = 0;
  int errors = 0;

  logic [9:0]  exp_q [$];
  logic [12:0] src_q [3][$];

  always #5 clk = ~clk;

  ftdi_tx_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(8)) dut (
    .in_clk             (clk),
    .in_rst             (in_rst),
    .in_req_tx_hsk_req  (req_vec),
    .in_req_tx_data     (data_vec),
    .in_req_last        (last_vec),
    .out_req_tx_hsk_ack (ack_vec),
    .out_tx_hsk_req     (tx_req),
    .in_tx_hsk_ack      (tx_ack),
    .out_tx_data        (tx_data),
    .out_grant          (grant),
    .out_busy           (busy),
    .out_timeout        (tmo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic exp_push(input logic [1:0] idx, input logic [7:0] d);
    exp_q.push_back({idx, d});
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l, input logic [3:0] gap);
    src_q[i].push_back({gap, l, d});
  endtask

  // Requester agents: each pops {gap,last,data} items and runs a four-phase handshake.
  for (genvar i = 0; i < 3; i++) begin : g_agent
    logic       req_v  = 1'b0;
    logic [7:0] dat_v  = 8'h00;
    logic       last_v = 1'b0;
    assign req_vec[i]         = req_v;
    assign data_vec[8*i +: 8] = dat_v;
    assign last_vec[i]        = last_v;
    initial begin
      logic [12:0] item;
      int budget;
      forever begin
        @(posedge clk); #1;
        if (!in_rst && src_q[i].size() > 0) begin
          item = src_q[i].pop_front();
          repeat (int'(item[12:9])) begin @(posedge clk); #1; end
          dat_v  = item[7:0];
          last_v = item[8];
          req_v  = 1'b1;
          budget = 0;
          while (!ack_vec[i] && !in_rst && budget < 200) begin
            @(posedge clk); #1; budget++;
          end
          if (budget >= 200) bound_fail("agent_ack_rise");
          req_v  = 1'b0;
          budget = 0;
          while (ack_vec[i] && !in_rst && budget < 200) begin
            @(posedge clk); #1; budget++;
          end
          if (budget >= 200) bound_fail("agent_ack_fall");
        end
      end
    end
  end

  // Downstream partner: acks lat cycles after request, drops when request falls.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (in_rst) begin
        tx_ack = 1'b0;
        cnt    = 0;
      end else if (tx_req && !tx_ack) begin
        if (cnt >= lat - 1) begin
          tx_ack = 1'b1;
          cnt    = 0;
        end else begin
          cnt++;
        end
      end else if (!tx_req && tx_ack) begin
        tx_ack = 1'b0;
      end
    end
  end

  // Monitor: compare each newly presented byte against the scoreboard queue.
  initial begin
    logic       prev;
    logic [9:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_req && !prev) begin
        if (exp_q.size() == 0) begin
          bound_fail("unexpected_byte");
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e[7:0]));
          check("grant", 32'(grant), 32'(3'b001 << e[9:8]));
        end
      end
      if (ack_vec != 3'b000) check("ack_matches_grant", 32'(ack_vec), 32'(grant));
      prev = tx_req;
    end
  end

  task automatic wait_done(input string name);
    int budget;
    budget = 0;
    while (!(exp_q.size() == 0 && !busy && req_vec == 3'b000 && src_q[0].size() == 0 &&
             src_q[1].size() == 0 && src_q[2].size() == 0) && budget < 500) begin
      @(negedge clk); budget++;
    end
    if (budget >= 500) bound_fail(name);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int budget;
    int n;
    in_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack_vec), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(tmo), 32'd0);
    in_rst = 1'b0;

    // Contention right after reset: pointer 0 favours requester 0.
    exp_push(2'd0, 8'h11); exp_push(2'd2, 8'h22);
    push(0, 8'h11, 1'b1, 4'd0); push(2, 8'h22, 1'b1, 4'd0);
    wait_done("contention_done");

    // Single 3-byte packet from requester 1, downstream latency 2.
    lat = 2;
    exp_push(2'd1, 8'hA5); exp_push(2'd1, 8'h5A); exp_push(2'd1, 8'h3C);
    push(1, 8'hA5, 1'b0, 4'd0); push(1, 8'h5A, 1'b0, 4'd0); push(1, 8'h3C, 1'b1, 4'd0);
    wait_done("single_done");
    check("single_grant_clear", 32'(grant), 32'd0);
    check("single_busy_clear", 32'(busy), 32'd0);

    // Fairness: pointer 2, so requester 0 first, then strict alternation.
    lat = 1;
    exp_push(2'd0, 8'hF0); exp_push(2'd1, 8'hE0); exp_push(2'd0, 8'hF1); exp_push(2'd1, 8'hE1);
    push(0, 8'hF0, 1'b1, 4'd0); push(0, 8'hF1, 1'b1, 4'd0);
    push(1, 8'hE0, 1'b1, 4'd0); push(1, 8'hE1, 1'b1, 4'd0);
    wait_done("fair_done");

    // Pointer now 2: requester 2 beats requester 0.
    exp_push(2'd2, 8'h88); exp_push(2'd0, 8'h77);
    push(0, 8'h77, 1'b1, 4'd0); push(2, 8'h88, 1'b1, 4'd0);
    wait_done("ptr_done");

    // Packet lock: requester 2 asks between the two bytes of requester 0.
    exp_push(2'd0, 8'h01); exp_push(2'd0, 8'h02); exp_push(2'd2, 8'h03);
    push(0, 8'h01, 1'b0, 4'd0); push(0, 8'h02, 1'b1, 4'd4);
    budget = 0;
    while (!ack_vec[0] && budget < 100) begin @(negedge clk); budget++; end
    if (budget >= 100) bound_fail("lock_ack_wait");
    push(2, 8'h03, 1'b1, 4'd0);
    wait_done("lock_done");

    // Timeout: requester 1 sends one non-last byte and goes silent.
    exp_push(2'd1, 8'h44);
    push(1, 8'h44, 1'b0, 4'd0);
    budget = 0;
    while (!ack_vec[1] && budget < 100) begin @(negedge clk); budget++; end
    if (budget >= 100) bound_fail("tmo_ack_rise");
    budget = 0;
    while (ack_vec[1] && budget < 100) begin @(negedge clk); budget++; end
    if (budget >= 100) bound_fail("tmo_ack_fall");
    n = 0;
    while (!tmo && n < 20) begin @(negedge clk); n++; end
    check("timeout_cycles", 32'(n), 32'd8);
    check("timeout_grant", 32'(grant), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("timeout_pulse_width", 32'(tmo), 32'd0);

    // Pointer after timeout is 2.
    exp_push(2'd2, 8'h66); exp_push(2'd0, 8'h55);
    push(0, 8'h55, 1'b1, 4'd0); push(2, 8'h66, 1'b1, 4'd0);
    wait_done("tmo_ptr_done");

    // Asynchronous reset while waiting for downstream ack.
    lat = 6;
    exp_push(2'd0, 8'h99);
    push(0, 8'h99, 1'b1, 4'd0);
    budget = 0;
    while (!tx_req && budget < 100) begin @(negedge clk); budget++; end
    if (budget >= 100) bound_fail("rst_req_wait");
    #2 in_rst = 1'b1;
    #1;
    check("midrst_tx_req", 32'(tx_req), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_ack", 32'(ack_vec), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    in_rst = 1'b0;
    lat = 1;
    exp_push(2'd0, 8'hC3);
    push(0, 8'hC3, 1'b1, 4'd0);
    wait_done("post_rst_done");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_arbiter.md
# ftdi_tx_arbiter

Round-robin arbiter that shares the single FTDI transmit byte channel of `ftdiController` between several byte producers. Producers include the command-reply path of `comm_handler`, the two-wire read-back stream and a status/event reporter. It sits between those producers and the `in_tx_hsk_req` / `out_tx_hsk_ack` / `in_tx_data` port of `ftdiController`. Each grant is held for a whole packet, so bytes from different producers never interleave on the USB link.

## Interface
- `NUM_REQ`, default 3: number of requesters; legal range 2..4.
- `TIMEOUT_CYC`, default 1024: number of idle cycles a granted requester may leave between bytes of one packet; legal range 2..65535.
- `in_clk` in 1: system clock (`clk_top_main`).
- `in_rst` in 1: reset, asynchronous, active-high.
- `in_req_tx_hsk_req` in NUM_REQ: per-requester byte request, four-phase.
- `in_req_tx_data` in 8*NUM_REQ: per-requester byte. Requester i occupies bits [8i+7:8i]. The byte must be stable while its request is high.
- `in_req_last` in NUM_REQ: marks this byte as the last of the packet. Stable while the request is high.
- `out_req_tx_hsk_ack` out NUM_REQ: per-requester acknowledge, four-phase.
- `out_tx_hsk_req` out 1: request to `ftdiController`.
- `in_tx_hsk_ack` in 1: acknowledge from `ftdiController`.
- `out_tx_data` out 8: byte to `ftdiController`, registered.
- `out_grant` out NUM_REQ: one-hot owner of the channel; all zero when there is no owner.
- `out_busy` out 1: high in every state except IDLE.
- `out_timeout` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- All outputs are registered. Reset drives every output to 0, the state to IDLE, the round-robin pointer `ptr` to 0 and the idle counter to 0.
- Handshake on both sides is four-phase: req rises, ack rises, req falls, ack falls.
- Winner search: scan from index `ptr` upward, wrapping modulo NUM_REQ. The first index with its request high wins.
- IDLE
  - If any request is high: set `out_grant` to the winner. Latch that requester's data into `out_tx_data` and its last flag into `last_q`. Raise `out_tx_hsk_req`. Go to WAIT_ACK.
- WAIT_ACK
  - On `in_tx_hsk_ack`=1: drop `out_tx_hsk_req` and raise `out_req_tx_hsk_ack[g]`. Go to RELAY.
- RELAY
  - When `in_req_tx_hsk_req[g]`=0 and `in_tx_hsk_ack`=0: drop `out_req_tx_hsk_ack[g]`.
  - If `last_q`=1: go to IDLE, set `ptr` = (g+1) mod NUM_REQ and clear `out_grant`.
  - Otherwise: clear the idle counter and go to HOLD.
- HOLD
  - If `in_req_tx_hsk_req[g]`=1: latch its data and last flag, raise `out_tx_hsk_req` and go to WAIT_ACK. Requests from other requesters are ignored in this state.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYC-1: pulse `out_timeout`, clear `out_grant`, set `ptr` = (g+1) mod NUM_REQ and go to IDLE.
- Requesters other than g never receive ack while g holds the grant. Their requests stay pending.
- A downstream ack that is already high on entry to WAIT_ACK is accepted. RELAY still waits for it to fall before the next byte.
- A requester dropping its request before ack rises is a protocol violation and is not handled.

## Timing
- A request seen in IDLE at edge n gives `out_tx_hsk_req`, `out_tx_data` and `out_grant` valid after edge n.
- `in_tx_hsk_ack` seen at edge m gives `out_req_tx_hsk_ack[g]`=1 and `out_tx_hsk_req`=0 after edge m.
- The requester ack falls one cycle after both the requester request and the downstream ack are sampled low.
- Minimum per byte with a zero-latency partner is 4 cycles: WAIT_ACK, RELAY, then HOLD or IDLE back to WAIT_ACK.
- The next packet's grant can issue in the cycle after IDLE is re-entered.
- Timeout fires exactly TIMEOUT_CYC cycles after HOLD entry.
- Asynchronous reset mid-transfer forces every output low immediately. The handshake partners must also be reset by the same `in_rst`.

## Test plan
- Single packet: requester 1 sends 0xA5, 0x5A, then 0x3C with last=1; downstream acks after 2 cycles.
  - Required: `out_tx_data` carries A5, 5A, 3C in order.
  - `out_grant`=3'b010 throughout, then 0; `ptr` ends at 2.
- Contention: requesters 0 and 2 both request one-byte packets (0x11 and 0x22, last=1) on the same cycle after reset.
  - Required: 0x11 is sent first, then 0x22. Requester 2 sees no ack until requester 0's ack has fallen.
- Fairness: requester 0 issues back-to-back one-byte packets while requester 1 also requests.
  - Required: grants alternate 0, 1, 0, 1. No requester gets two consecutive grants while the other is pending.
- Packet lock: requester 0 sends a 2-byte packet; requester 2 requests between those bytes.
  - Required: both bytes from requester 0 go out before the byte from requester 2.
- Timeout: with TIMEOUT_CYC=8, requester 1 sends one byte with last=0 and then goes silent.
  - Required: `out_timeout` pulses exactly 8 cycles after HOLD entry, then `out_grant`=0 and `ptr`=2.
- Reset mid-transfer: assert `in_rst` while in WAIT_ACK.
  - Required: all outputs are 0 within the same cycle.
  - After release, a new request from requester 0 is sent normally.
